// File: rtl/ntt_bfu_pipe.sv
// Pipelined NTT/INTT butterfly (CT forward, GS inverse with optional halving)
// fed by ping-pong U/L coefficient banks with in-place result writeback.
module ntt_bfu_pipe #(
    parameter int W          = 14,
    parameter int Q          = 12289,
    parameter int DEPTH      = 512,
    parameter int MUL_STAGES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     dir,
    input  logic                     scale,
    input  logic                     byp,
    input  logic                     rd_sel,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_u,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_l,
    input  logic [W-1:0]             twiddle,
    input  logic [W-1:0]             byp_a,
    input  logic [W-1:0]             byp_b,
    input  logic                     wb_en,
    input  logic [$clog2(DEPTH)-1:0] wb_addr_u,
    input  logic [$clog2(DEPTH)-1:0] wb_addr_l,
    input  logic                     wr_en,
    input  logic                     wr_bank,
    input  logic                     wr_sel,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    output logic                     out_valid,
    output logic [W-1:0]             out_a,
    output logic [W-1:0]             out_b,
    output logic                     busy,
    output logic                     wr_conflict
);
    localparam int               AW  = $clog2(DEPTH);
    localparam logic [W:0]       QW1 = (W+1)'(Q);
    localparam logic [2*W-1:0]   Q2W = (2*W)'(Q);

    typedef struct packed {
        logic          dir;
        logic          scale;
        logic          wb_en;
        logic          wbuf;
        logic [AW-1:0] au;
        logic [AW-1:0] al;
    } ctl_t;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QW1) s = s - QW1;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (x < y) d = d + QW1;
        return d[W-1:0];
    endfunction

    // Odd values become even by adding Q, so the shift is exact mod Q.
    function automatic logic [W-1:0] mod_half(input logic [W-1:0] x);
        logic [W:0] h;
        h = x[0] ? ({1'b0, x} + QW1) : {1'b0, x};
        return h[W:1];
    endfunction

    function automatic logic [W-1:0] mod_red(input logic [2*W-1:0] p);
        logic [2*W-1:0] r;
        r = p % Q2W;
        return r[W-1:0];
    endfunction

    logic                  r_vld_p0, r_byp_p0, r_sel_p0;
    ctl_t                  r_ctl_p0;
    logic [W-1:0]          r_bypa_p0, r_bypb_p0, r_tw_p0;
    logic [W-1:0]          w_a_p0, w_b_p0;
    logic                  r_vld_p1;
    ctl_t                  r_ctl_p1;
    logic [W-1:0]          r_a_p1, r_m_p1, r_tw_p1;
    logic [MUL_STAGES-1:0] r_vld_pm;
    ctl_t                  r_ctl_pm  [MUL_STAGES];
    logic [W-1:0]          r_a_pm    [MUL_STAGES];
    logic [2*W-1:0]        r_prod_pm [MUL_STAGES];
    logic [W-1:0]          w_t_pm, w_oa_pm, w_ob_pm;
    logic                  r_vld_p2, r_wben_p2, r_wbuf_p2;
    logic [AW-1:0]         r_au_p2, r_al_p2;
    logic [W-1:0]          r_oa_p2, r_ob_p2;
    logic                  r_out_valid, r_wben_o, r_wbuf_o, r_wr_conflict;
    logic [AW-1:0]         r_au_o, r_al_o;
    logic [W-1:0]          r_out_a, r_out_b;
    logic                  w_wb_act, w_wr_drop;

    assign w_wb_act  = r_out_valid && r_wben_o;
    assign w_wr_drop = w_wb_act && (wr_sel == r_wbuf_o);

    // Four bank-buffers (index = {bank, buffer}); each has one write port,
    // writeback wins over the external load port.
    for (genvar g = 0; g < 4; g++) begin : g_mem
        localparam bit BANK = (g >= 2);
        localparam bit BSEL = ((g % 2) == 1);
        logic [W-1:0]  r_mem [DEPTH];
        logic [W-1:0]  r_rd;
        logic          w_wb_hit, w_ext_hit, w_we;
        logic [AW-1:0] w_waddr;
        logic [W-1:0]  w_wdata;

        assign w_wb_hit  = w_wb_act && (r_wbuf_o == BSEL);
        assign w_ext_hit = wr_en && (wr_bank == BANK) && (wr_sel == BSEL) && !w_wr_drop;
        assign w_we      = w_wb_hit || w_ext_hit;
        assign w_waddr   = w_wb_hit ? (BANK ? r_al_o : r_au_o) : wr_addr;
        assign w_wdata   = w_wb_hit ? (BANK ? r_out_b : r_out_a) : wr_data;

        always_ff @(posedge clk) begin
            if (w_we) r_mem[w_waddr] <= w_wdata;
            if (in_valid && !byp) r_rd <= r_mem[BANK ? rd_addr_l : rd_addr_u];
        end
    end

    // ---- Stage 0: operand fetch / bypass capture ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_vld_p0 <= 1'b0;
        else     r_vld_p0 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_ctl_p0  <= {dir, scale, wb_en, ~rd_sel, wb_addr_u, wb_addr_l};
            r_byp_p0  <= byp;
            r_sel_p0  <= rd_sel;
            r_bypa_p0 <= byp_a;
            r_bypb_p0 <= byp_b;
            r_tw_p0   <= twiddle;
        end
    end

    assign w_a_p0 = r_byp_p0 ? r_bypa_p0 : (r_sel_p0 ? g_mem[1].r_rd : g_mem[0].r_rd);
    assign w_b_p0 = r_byp_p0 ? r_bypb_p0 : (r_sel_p0 ? g_mem[3].r_rd : g_mem[2].r_rd);

    // ---- Stage 1: inverse add/sub ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_vld_p1 <= 1'b0;
        else     r_vld_p1 <= r_vld_p0;
    end

    always_ff @(posedge clk) begin
        if (r_vld_p0) begin
            r_ctl_p1 <= r_ctl_p0;
            r_tw_p1  <= r_tw_p0;
            if (r_ctl_p0.dir) begin
                r_a_p1 <= mod_add(w_a_p0, w_b_p0);
                r_m_p1 <= mod_sub(w_a_p0, w_b_p0);
            end else begin
                r_a_p1 <= w_a_p0;
                r_m_p1 <= w_b_p0;
            end
        end
    end

    // ---- Stages 2..MUL_STAGES+1: product pipeline, reduced at its tail ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pm <= '0;
        end else begin
            r_vld_pm[0] <= r_vld_p1;
            for (int k = 1; k < MUL_STAGES; k++) r_vld_pm[k] <= r_vld_pm[k-1];
        end
    end

    always_ff @(posedge clk) begin
        r_ctl_pm[0]  <= r_ctl_p1;
        r_a_pm[0]    <= r_a_p1;
        r_prod_pm[0] <= {{W{1'b0}}, r_m_p1} * {{W{1'b0}}, r_tw_p1};
        for (int k = 1; k < MUL_STAGES; k++) begin
            r_ctl_pm[k]  <= r_ctl_pm[k-1];
            r_a_pm[k]    <= r_a_pm[k-1];
            r_prod_pm[k] <= r_prod_pm[k-1];
        end
    end

    assign w_t_pm = mod_red(r_prod_pm[MUL_STAGES-1]);

    always_comb begin
        w_oa_pm = r_a_pm[MUL_STAGES-1];
        w_ob_pm = w_t_pm;
        if (!r_ctl_pm[MUL_STAGES-1].dir) begin
            w_oa_pm = mod_add(r_a_pm[MUL_STAGES-1], w_t_pm);
            w_ob_pm = mod_sub(r_a_pm[MUL_STAGES-1], w_t_pm);
        end else if (r_ctl_pm[MUL_STAGES-1].scale) begin
            w_oa_pm = mod_half(r_a_pm[MUL_STAGES-1]);
            w_ob_pm = mod_half(w_t_pm);
        end
    end

    // ---- Stage MUL_STAGES+2: forward add/sub or inverse halving ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_vld_p2 <= 1'b0;
        else     r_vld_p2 <= r_vld_pm[MUL_STAGES-1];
    end

    always_ff @(posedge clk) begin
        r_oa_p2   <= w_oa_pm;
        r_ob_p2   <= w_ob_pm;
        r_wben_p2 <= r_ctl_pm[MUL_STAGES-1].wb_en;
        r_wbuf_p2 <= r_ctl_pm[MUL_STAGES-1].wbuf;
        r_au_p2   <= r_ctl_pm[MUL_STAGES-1].au;
        r_al_p2   <= r_ctl_pm[MUL_STAGES-1].al;
    end

    // ---- Output register; also the pending-writeback slot ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_a       <= '0;
            r_out_b       <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_out_valid   <= r_vld_p2;
            r_wr_conflict <= wr_en && w_wr_drop;
            if (r_vld_p2) begin
                r_out_a <= r_oa_p2;
                r_out_b <= r_ob_p2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_vld_p2) begin
            r_wben_o <= r_wben_p2;
            r_wbuf_o <= r_wbuf_p2;
            r_au_o   <= r_au_p2;
            r_al_o   <= r_al_p2;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign wr_conflict = r_wr_conflict;
    assign busy        = r_vld_p0 | r_vld_p1 | (|r_vld_pm) | r_vld_p2 | r_out_valid;

endmodule

// File: tb/tb_ntt_bfu_pipe.sv
// Bench for ntt_bfu_pipe: directed literal cases plus randomized traffic
// compared every cycle against a queue-based modular-arithmetic model.
module tb_ntt_bfu_pipe;
    localparam int W = 14, Q = 12289, DEPTH = 512, MS = 3, LAT = MS + 3, AW = 9;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid, dir, scale, byp, rd_sel, wb_en, wr_en, wr_bank, wr_sel;
    logic [AW-1:0] rd_addr_u, rd_addr_l, wb_addr_u, wb_addr_l, wr_addr;
    logic [W-1:0]  twiddle, byp_a, byp_b, wr_data;
    logic          out_valid, busy, wr_conflict;
    logic [W-1:0]  out_a, out_b;

    ntt_bfu_pipe #(.W(W), .Q(Q), .DEPTH(DEPTH), .MUL_STAGES(MS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .dir(dir), .scale(scale), .byp(byp),
        .rd_sel(rd_sel), .rd_addr_u(rd_addr_u), .rd_addr_l(rd_addr_l), .twiddle(twiddle),
        .byp_a(byp_a), .byp_b(byp_b), .wb_en(wb_en), .wb_addr_u(wb_addr_u),
        .wb_addr_l(wb_addr_l), .wr_en(wr_en), .wr_bank(wr_bank), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid), .out_a(out_a),
        .out_b(out_b), .busy(busy), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due; int a; int b; bit wb; bit wbuf; int au; int al;
    } res_t;

    res_t resq[$];
    res_t wbq[$];
    int   mu[2][DEPTH];
    int   ml[2][DEPTH];
    int   cyc = 0;
    bit   cur_v = 1'b0, exp_wc = 1'b0;
    int   exp_a = 0, exp_b = 0;

    function automatic int half(input int x);
        return (x * ((Q + 1) / 2)) % Q;
    endfunction

    task automatic ref_bfu(input bit d, input bit s, input int a, input int b, input int w,
                           output int oa, output int ob);
        int t;
        if (!d) begin
            t  = (w * b) % Q;
            oa = (a + t) % Q;
            ob = (a - t + Q) % Q;
        end else begin
            oa = (a + b) % Q;
            ob = (((a - b + Q) % Q) * w) % Q;
            if (s) begin
                oa = half(oa);
                ob = half(ob);
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin : model
        res_t r;
        bit   wbact;
        res_t wi;
        int   a, b;
        if (rst) begin
            resq.delete();
            wbq.delete();
            cur_v  = 1'b0;
            exp_a  = 0;
            exp_b  = 0;
            exp_wc = 1'b0;
        end else begin
            cyc++;
            wbact = 1'b0;
            if (wbq.size() > 0 && wbq[0].due == cyc) begin
                wbact = 1'b1;
                wi = wbq.pop_front();
            end
            if (in_valid) begin
                a = byp ? int'(byp_a) : mu[rd_sel][rd_addr_u];
                b = byp ? int'(byp_b) : ml[rd_sel][rd_addr_l];
                ref_bfu(dir, scale, a, b, int'(twiddle), r.a, r.b);
                r.due  = cyc + LAT;
                r.wb   = wb_en;
                r.wbuf = !rd_sel;
                r.au   = int'(wb_addr_u);
                r.al   = int'(wb_addr_l);
                resq.push_back(r);
            end
            if (wbact) begin
                mu[wi.wbuf][wi.au] = wi.a;
                ml[wi.wbuf][wi.al] = wi.b;
            end
            exp_wc = 1'b0;
            if (wr_en) begin
                if (wbact && (wr_sel == wi.wbuf)) exp_wc = 1'b1;
                else if (wr_bank) ml[wr_sel][wr_addr] = int'(wr_data);
                else              mu[wr_sel][wr_addr] = int'(wr_data);
            end
            cur_v = 1'b0;
            if (resq.size() > 0 && resq[0].due == cyc) begin
                r = resq.pop_front();
                cur_v = 1'b1;
                exp_a = r.a;
                exp_b = r.b;
                if (r.wb) begin
                    r.due = cyc + 1;
                    wbq.push_back(r);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(cur_v));
        chk("out_a", 32'(out_a), 32'(exp_a));
        chk("out_b", 32'(out_b), 32'(exp_b));
        chk("busy", 32'(busy), 32'((resq.size() > 0) || cur_v));
        chk("wr_conflict", 32'(wr_conflict), 32'(exp_wc));
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        in_valid = 0; dir = 0; scale = 0; byp = 0; rd_sel = 0; rd_addr_u = '0; rd_addr_l = '0;
        twiddle = '0; byp_a = '0; byp_b = '0; wb_en = 0; wb_addr_u = '0; wb_addr_l = '0;
        wr_en = 0; wr_bank = 0; wr_sel = 0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic ext_wr(input bit bank, input bit sel, input int addr, input int data);
        wr_en = 1; wr_bank = bank; wr_sel = sel; wr_addr = AW'(addr); wr_data = W'(data);
        step();
    endtask

    task automatic issue(input bit d, input bit s, input bit bp, input bit sel,
                         input int au, input int al, input int w, input int a, input int b,
                         input bit wb, input int wau, input int wal);
        in_valid = 1; dir = d; scale = s; byp = bp; rd_sel = sel;
        rd_addr_u = AW'(au); rd_addr_l = AW'(al); twiddle = W'(w);
        byp_a = W'(a); byp_b = W'(b); wb_en = wb; wb_addr_u = AW'(wau); wb_addr_l = AW'(wal);
        step();
    endtask

    task automatic byp_case(input string nm, input bit d, input bit s, input int a, input int b,
                            input int w, input int ea, input int eb);
        issue(d, s, 1, 0, 0, 0, w, a, b, 0, 0, 0);
        repeat (LAT - 1) step();
        chk({nm, "_early"}, 32'(out_valid), 0);
        step();
        chk({nm, "_v"}, 32'(out_valid), 1);
        chk({nm, "_a"}, 32'(out_a), ea);
        chk({nm, "_b"}, 32'(out_b), eb);
    endtask

    initial begin
        int j, cnt, first, last, seen;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        for (int s = 0; s < 2; s++)
            for (int bk = 0; bk < 2; bk++)
                for (int ad = 0; ad < 16; ad++)
                    ext_wr(1'(bk), 1'(s), ad, int'($urandom_range(Q - 1)));

        byp_case("fwd", 0, 0, 5, 3, 2, 11, 12288);
        byp_case("inv", 1, 0, 5, 3, 2, 8, 4);
        byp_case("inv_sc", 1, 1, 5, 3, 2, 4, 2);
        byp_case("inv_sc_odd", 1, 1, 4, 1, 1, 6147, 6146);

        // load, compute, writeback to buffer 1, read back
        ext_wr(0, 0, 0, 100);
        ext_wr(1, 0, 0, 10);
        issue(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 3);
        repeat (LAT) step();
        chk("load_v", 32'(out_valid), 1);
        chk("load_a", 32'(out_a), 110);
        chk("load_b", 32'(out_b), 90);
        issue(0, 0, 0, 1, 3, 3, 1, 0, 0, 0, 0, 0);
        step();
        issue(0, 0, 0, 1, 3, 3, 1, 0, 0, 0, 0, 0);
        repeat (LAT) step();
        chk("readback_a", 32'(out_a), 200);
        chk("readback_b", 32'(out_b), 20);
        repeat (LAT) step();

        // streaming
        j = 0; cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 8; i++) begin
            issue(0, 0, 0, 1'($urandom_range(1)), int'($urandom_range(15)),
                  int'($urandom_range(15)), int'($urandom_range(Q - 1)), 0, 0, 0, 0, 0);
            j++;
            if (out_valid) begin cnt++; if (first < 0) first = j; last = j; end
        end
        for (int k = 0; k < LAT + 4; k++) begin
            step();
            j++;
            if (out_valid) begin cnt++; if (first < 0) first = j; last = j; end
        end
        chk("stream_cnt", 32'(cnt), 8);
        chk("stream_span", 32'(last - first + 1), 8);

        // write conflict: writeback to buffer 1 drops the U[1][5] write
        ext_wr(0, 1, 5, 777);
        issue(0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 7, 7);
        repeat (LAT) step();
        ext_wr(0, 1, 5, 1234);
        chk("conf_pulse", 32'(wr_conflict), 1);
        step();
        chk("conf_once", 32'(wr_conflict), 0);
        issue(0, 0, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0);
        repeat (LAT) step();
        chk("conf_dropped", 32'(out_a), 777);
        // same write while writeback targets buffer 0 proceeds
        issue(0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 7, 7);
        repeat (LAT) step();
        ext_wr(0, 1, 5, 1234);
        chk("noconf_pulse", 32'(wr_conflict), 0);
        issue(0, 0, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0);
        repeat (LAT) step();
        chk("noconf_written", 32'(out_a), 1234);
        repeat (3) step();

        // reset mid-flight
        ext_wr(0, 1, 9, 321);
        ext_wr(1, 1, 9, 654);
        issue(0, 0, 1, 0, 0, 0, 2, 5, 3, 1, 9, 9);
        step();
        chk("busy_pre_rst", 32'(busy), 1);
        #2 rst = 1'b1;
        #1 chk("busy_rst_async", 32'(busy), 0);
        chk("valid_rst_async", 32'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < LAT + 3; k++) begin
            step();
            if (out_valid) seen++;
        end
        chk("rst_no_out", 32'(seen), 0);
        byp_case("post_rst", 0, 0, 5, 3, 2, 11, 12288);
        issue(1, 0, 0, 1, 9, 9, 1, 0, 0, 0, 0, 0);
        repeat (LAT) step();
        chk("rst_mem_a", 32'(out_a), 975);
        chk("rst_mem_b", 32'(out_b), 11956);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            dir       = 1'($urandom_range(1));
            scale     = 1'($urandom_range(1));
            byp       = 1'($urandom_range(1));
            rd_sel    = 1'($urandom_range(1));
            rd_addr_u = AW'($urandom_range(15));
            rd_addr_l = AW'($urandom_range(15));
            twiddle   = W'($urandom_range(Q - 1));
            byp_a     = W'($urandom_range(Q - 1));
            byp_b     = W'($urandom_range(Q - 1));
            wb_en     = 1'($urandom_range(1));
            wb_addr_u = AW'($urandom_range(15));
            wb_addr_l = AW'($urandom_range(15));
            wr_en     = ($urandom_range(2) == 0);
            wr_bank   = 1'($urandom_range(1));
            wr_sel    = 1'($urandom_range(1));
            wr_addr   = AW'($urandom_range(15));
            wr_data   = W'($urandom_range(Q - 1));
            step();
        end
        repeat (LAT + 4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
